proc_controller: RTL and testbench

PROC_CONTROLLER -- requirements
Module: proc_controller

---
 rtl/proc_controller_if.sv | 42 ++++
 rtl/proc_controller.sv | 136 +++++++++++++
 tb/tb_proc_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/proc_controller_if.sv
// Control bundle between the instruction sequencer and the register/ALU datapath.
//   run, din          : start request and instruction/immediate word (into the controller)
//   ir_load           : capture din into IR
//   rout_sel, rout_en : register index onto the bus and its enable
//   din_out, gout     : din-to-bus and G-to-bus enables
//   rin               : one-hot register write enables, R0=1000 .. R3=0001
//   ain, gin, addsub  : A-load, G-load, ALU op (0=add, 1=sub)
//   done, busy, err   : completion pulse, not-idle, illegal-instruction pulse
//   instr_count       : retired-instruction count
interface proc_controller_if #(
  parameter int unsigned CNT_W = 8
);
  logic             run;
  logic [8:0]       din;
  logic             ir_load;
  logic [2:0]       rout_sel;
  logic             rout_en;
  logic             din_out;
  logic [3:0]       rin;
  logic             ain;
  logic             gin;
  logic             gout;
  logic             addsub;
  logic             done;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] instr_count;

  // Datapath / stimulus side.
  modport master (
    output run, din,
    input  ir_load, rout_sel, rout_en, din_out, rin, ain, gin, gout, addsub,
           done, busy, err, instr_count
  );

  // Controller side.
  modport slave (
    input  run, din,
    output ir_load, rout_sel, rout_en, din_out, rin, ain, gin, gout, addsub,
           done, busy, err, instr_count
  );
endinterface

// File: rtl/proc_controller.sv
// Multi-cycle control FSM for a small 4-register processor.
// Instruction word {op[8:6], rx[5:3], ry[2:0]}:
//   000 mv  rx <- ry          (1 execute cycle)
//   001 mvi rx <- din         (1 execute cycle, immediate presented on din in T1)
//   010 add rx <- rx + ry     (3 execute cycles)
//   011 sub rx <- rx - ry     (3 execute cycles)
// Anything else, or a register index >= 4, retires as an error with no writes.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : controller side of proc_controller_if (see interface header)
module proc_controller #(
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               resetn,
  proc_controller_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_e;

  state_e           state_q, state_d;
  logic [8:0]       ir_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0] op, rx, ry;
  logic       illegal;
  logic [3:0] rin_rx;

  logic       ir_load;
  logic [2:0] rout_sel;
  logic       rout_en, din_out, ain, gin, gout, addsub, done, busy, err;
  logic [3:0] rin;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  // mvi does not use ry, so only mv/add/sub reject ry >= 4.
  assign illegal = op[2] | rx[2] | (ry[2] & (op != 3'b001));
  assign rin_rx  = 4'b1000 >> rx[1:0];

  // Only ir_load looks at run; masking with resetn keeps it low during reset.
  assign ir_load = (state_q == StIdle) & bus.run & resetn;

  always_comb begin
    state_d  = state_q;
    rout_sel = 3'd0;
    rout_en  = 1'b0;
    din_out  = 1'b0;
    rin      = 4'b0000;
    ain      = 1'b0;
    gin      = 1'b0;
    gout     = 1'b0;
    addsub   = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    busy     = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (bus.run) state_d = StT1;
      end
      StT1: begin
        state_d = StIdle;
        if (illegal) begin
          done = 1'b1;
          err  = 1'b1;
        end else begin
          unique case (op[1:0])
            2'b00: begin
              rout_en  = 1'b1;
              rout_sel = ry;
              rin      = rin_rx;
              done     = 1'b1;
            end
            2'b01: begin
              din_out = 1'b1;
              rin     = rin_rx;
              done    = 1'b1;
            end
            default: begin
              // add/sub: first operand into A
              rout_en  = 1'b1;
              rout_sel = rx;
              ain      = 1'b1;
              state_d  = StT2;
            end
          endcase
        end
      end
      StT2: begin
        rout_en  = 1'b1;
        rout_sel = ry;
        gin      = 1'b1;
        addsub   = op[0];
        state_d  = StT3;
      end
      StT3: begin
        gout    = 1'b1;
        rin     = rin_rx;
        addsub  = op[0];
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      ir_q    <= 9'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.run) ir_q <= bus.din;
      if (done && !err) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.ir_load     = ir_load;
  assign bus.rout_sel    = rout_sel;
  assign bus.rout_en     = rout_en;
  assign bus.din_out     = din_out;
  assign bus.rin         = rin;
  assign bus.ain         = ain;
  assign bus.gin         = gin;
  assign bus.gout        = gout;
  assign bus.addsub      = addsub;
  assign bus.done        = done;
  assign bus.busy        = busy;
  assign bus.err         = err;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_proc_controller.sv
// Directed bench for proc_controller: one 8-bit-counter instance for the main
// sequence and a 2-bit-counter instance for counter wrap.
module tb_proc_controller;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  proc_controller_if #(.CNT_W(8)) bus ();
  proc_controller_if #(.CNT_W(2)) bus2 ();

  proc_controller #(.CNT_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  proc_controller #(.CNT_W(2)) dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2)
  );

  // Packed expected outputs: {ir_load, rout_sel, rout_en, din_out, rin, ain, gin, gout,
  // addsub, done, busy, err}
  function automatic logic [16:0] ev(input logic ir, input logic [2:0] sel, input logic ren,
                                     input logic dout, input logic [3:0] rin, input logic ain,
                                     input logic gin, input logic gout, input logic as,
                                     input logic dn, input logic bsy, input logic er);
    return {ir, sel, ren, dout, rin, ain, gin, gout, as, dn, bsy, er};
  endfunction

  task automatic chk_out(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    obs = {bus.ir_load, bus.rout_sel, bus.rout_en, bus.din_out, bus.rin, bus.ain, bus.gin,
           bus.gout, bus.addsub, bus.done, bus.busy, bus.err};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] wrap_exp [4];

  initial begin
    wrap_exp[0] = 2'd1;
    wrap_exp[1] = 2'd2;
    wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0;

    bus.run  = 1'b0;
    bus.din  = 9'd0;
    bus2.run = 1'b0;
    bus2.din = 9'd0;

    // Reset: outputs low, ir_load masked even with run high.
    tick(); tick();
    bus.run = 1'b1;
    #1;
    chk_out("reset_outputs", 17'h0);
    chk_val("reset_count", bus.instr_count, 0);
    bus.run = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // mv R1 <- R2
    bus.run = 1'b1; bus.din = 9'b000_001_010; #1;
    chk_out("mv_idle", ev(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    tick();
    bus.run = 1'b0; bus.din = 9'd0; #1;
    chk_out("mv_t1", ev(0, 3'd2, 1, 0, 4'b0100, 0, 0, 0, 0, 1, 1, 0));
    tick(); #1;
    chk_out("mv_after", 17'h0);
    chk_val("mv_count", bus.instr_count, 1);

    // mvi R3 <- 5
    bus.run = 1'b1; bus.din = 9'b001_011_000; #1;
    chk_out("mvi_idle", ev(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    tick();
    bus.run = 1'b0; bus.din = 9'h005; #1;
    chk_out("mvi_t1", ev(0, 0, 0, 1, 4'b0001, 0, 0, 0, 0, 1, 1, 0));
    tick(); #1;
    chk_val("mvi_count", bus.instr_count, 2);

    // sub R0 <- R0 - R1
    bus.run = 1'b1; bus.din = 9'b011_000_001;
    tick();
    bus.run = 1'b0; bus.din = 9'd0; #1;
    chk_out("sub_t1", ev(0, 3'd0, 1, 0, 4'b0000, 1, 0, 0, 0, 0, 1, 0));
    tick(); #1;
    chk_out("sub_t2", ev(0, 3'd1, 1, 0, 4'b0000, 0, 1, 0, 1, 0, 1, 0));
    tick(); #1;
    chk_out("sub_t3", ev(0, 3'd0, 0, 0, 4'b1000, 0, 0, 1, 1, 1, 1, 0));
    tick(); #1;
    chk_val("sub_count", bus.instr_count, 3);

    // add R2 <- R2 + R3 with run held high throughout: ignored while busy,
    // then a fresh ir_load in the single IDLE cycle after done.
    bus.run = 1'b1; bus.din = 9'b010_010_011;
    tick();
    bus.din = 9'b110_111_111; #1;
    chk_out("add_t1", ev(0, 3'd2, 1, 0, 4'b0000, 1, 0, 0, 0, 0, 1, 0));
    tick(); #1;
    chk_out("add_t2", ev(0, 3'd3, 1, 0, 4'b0000, 0, 1, 0, 0, 0, 1, 0));
    tick(); #1;
    chk_out("add_t3", ev(0, 3'd0, 0, 0, 4'b0010, 0, 0, 1, 0, 1, 1, 0));
    tick(); #1;
    chk_out("add_gap_idle", ev(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    chk_val("add_count", bus.instr_count, 4);
    // That din (op 110) starts as an illegal instruction.
    tick();
    bus.run = 1'b0; bus.din = 9'd0; #1;
    chk_out("illegal_op_t1", ev(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 1, 1));
    tick(); #1;
    chk_val("illegal_op_count", bus.instr_count, 4);

    // mv with rx=5
    bus.run = 1'b1; bus.din = 9'b000_101_000;
    tick();
    bus.run = 1'b0; #1;
    chk_out("illegal_rx_t1", ev(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 1, 1));
    tick(); #1;
    chk_val("illegal_rx_count", bus.instr_count, 4);

    // mv with ry=4
    bus.run = 1'b1; bus.din = 9'b000_000_100;
    tick();
    bus.run = 1'b0; #1;
    chk_out("illegal_ry_t1", ev(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 1, 1));
    tick();

    // mvi ignores ry, so ry=7 is still legal
    bus.run = 1'b1; bus.din = 9'b001_010_111;
    tick();
    bus.run = 1'b0; #1;
    chk_out("mvi_ry7_t1", ev(0, 0, 0, 1, 4'b0010, 0, 0, 0, 0, 1, 1, 0));
    tick(); #1;
    chk_val("mvi_ry7_count", bus.instr_count, 5);

    // Reset in T2 of add: immediate abort, no rin pulse afterwards.
    bus.run = 1'b1; bus.din = 9'b010_001_000;
    tick();
    bus.run = 1'b0; tick(); #1;
    chk_out("rst_add_t2", ev(0, 3'd0, 1, 0, 4'b0000, 0, 1, 0, 0, 0, 1, 0));
    resetn = 1'b0; #1;
    chk_out("rst_async_outputs", 17'h0);
    chk_val("rst_async_count", bus.instr_count, 0);
    tick(); #1;
    chk_out("rst_held_outputs", 17'h0);
    resetn = 1'b1;
    tick(); #1;
    chk_out("rst_release_idle", 17'h0);

    // Normal operation after reset: mv R3 <- R0
    bus.run = 1'b1; bus.din = 9'b000_011_000;
    tick();
    bus.run = 1'b0; #1;
    chk_out("post_rst_mv_t1", ev(0, 3'd0, 1, 0, 4'b0001, 0, 0, 0, 0, 1, 1, 0));
    tick(); #1;
    chk_val("post_rst_count", bus.instr_count, 1);

    // Counter wrap on the 2-bit instance, run held high.
    bus2.run = 1'b1; bus2.din = 9'b000_001_000;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_val("wrap_ir_load", {31'd0, bus2.ir_load}, 1);
      tick(); #1;
      chk_val("wrap_done", {31'd0, bus2.done}, 1);
      tick(); #1;
      chk_val("wrap_count", {30'd0, bus2.instr_count}, {30'd0, wrap_exp[i]});
    end
    bus2.run = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
